// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the operation encodings presented on the Op port, the control FSM
// state encodings and the default operand width.
package mdu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: combinational step and sign-correction logic for the
// multiply/divide unit. The accumulator pair {acc_hi, acc_lo} is owned by
// the top level; this block computes its next value for one iteration and
// the final HI/LO values produced when the operation closes.
//
// Ports:
//   is_div            1 = restoring-divide step, 0 = shift-add multiply step
//   acc_hi, acc_lo    current accumulator (partial product / remainder,
//                     multiplier / dividend-quotient)
//   operand           |B|: multiplicand or divisor magnitude
//   sign_a, sign_b    sign flags latched at start (0 for unsigned ops)
//   a_raw             original A, returned as HI on divide by zero
//   step_hi, step_lo  accumulator after one iteration
//   res_hi, res_lo    sign-corrected result to be written into HI/LO
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [WIDTH-1:0] a_raw,
    output logic [WIDTH-1:0] step_hi,
    output logic [WIDTH-1:0] step_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] product;
    logic               neg;

    // One iteration. Multiply: add the multiplicand when the low multiplier
    // bit is set, then shift the whole pair right, carry included.
    // Divide: shift the remainder left pulling in the next dividend bit,
    // subtract the divisor if it fits, and shift the quotient bit into acc_lo.
    // When the subtraction succeeds the difference is below the divisor, so
    // the low WIDTH bits of the difference are exact.
    always_comb begin
        addend  = acc_lo[0] ? operand : '0;
        sum     = {1'b0, acc_hi} + {1'b0, addend};
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, operand});
        diff    = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            step_hi = ge ? diff : shifted[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Final correction. The product is negated as a full double-width value.
    // Quotient takes the xor of the signs; the remainder follows the dividend.
    // A zero divisor bypasses the iteration result entirely.
    always_comb begin
        product = {acc_hi, acc_lo};
        neg     = sign_a ^ sign_b;
        res_hi  = '0;
        res_lo  = '0;
        if (!is_div) begin
            if (neg) begin
                product = -product;
            end
            res_hi = product[2*WIDTH-1:WIDTH];
            res_lo = product[WIDTH-1:0];
        end else if (operand == '0) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_lo = neg    ? -acc_lo : acc_lo;
            res_hi = sign_a ? -acc_hi : acc_hi;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit for the EXE stage.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) one bit per cycle,
// owns the architectural HI/LO registers and raises Busy while an
// operation is in flight so the hazard logic can stall the front end.
//
// Ports:
//   Clk          rising-edge clock
//   Reset        asynchronous, active-low reset
//   Start        launch an operation (honoured only when idle)
//   Op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B         rs / rt operands, sampled at the Start edge only
//   Wr_Hi, Wr_Lo MTHI / MTLO: write A into HI / LO while idle
//   Flush        synchronous abort
//   Busy         operation in flight
//   Done         one-cycle pulse when HI/LO take a new result
//   HI, LO       architectural HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Wr_Hi,
    input  logic             Wr_Lo,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic             done_reg;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             start_div;
    logic             start_signed;
    logic             start_sign_a;
    logic             start_sign_b;

    assign start_div    = (Op == OP_DIVU) || (Op == OP_DIV);
    assign start_signed = (Op == OP_MULT) || (Op == OP_DIV);
    assign start_sign_a = start_signed & A[WIDTH-1];
    assign start_sign_b = start_signed & B[WIDTH-1];

    mdu_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .is_div (is_div),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .operand(operand),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .a_raw  (a_raw),
        .step_hi(step_hi),
        .step_lo(step_lo),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush wins everywhere: it blocks a launch from IDLE and aborts RUN/FIX.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (Start && !Flush) next_state = S_RUN;
            S_RUN: begin
                if (Flush) begin
                    next_state = S_IDLE;
                end else if (count == LAST) begin
                    next_state = S_FIX;
                end
            end
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Both multiply and divide start from {0, |A|} with |B| held aside, so
    // the launch is the same for every op. MT writes land in the launch cycle
    // too; the FIX write later overwrites them.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state == S_FIX) && !Flush;
            case (state)
                S_IDLE: begin
                    if (!Flush) begin
                        if (Wr_Hi) hi_reg <= A;
                        if (Wr_Lo) lo_reg <= A;
                        if (Start) begin
                            count   <= '0;
                            acc_hi  <= '0;
                            acc_lo  <= start_sign_a ? -A : A;
                            operand <= start_sign_b ? -B : B;
                            a_raw   <= A;
                            is_div  <= start_div;
                            sign_a  <= start_sign_a;
                            sign_b  <= start_sign_b;
                        end
                    end
                end
                S_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                end
                S_FIX: begin
                    if (!Flush) begin
                        hi_reg <= res_hi;
                        lo_reg <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != S_IDLE);
    assign Done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit. Directed corner
// cases plus randomized operations, all compared against a plain-arithmetic
// model of the architectural HI/LO registers.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Wr_Hi;
    logic         Wr_Lo;
    logic         Flush;
    logic         Busy;
    logic         Done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int errors = 0;
    int checks = 0;

    logic [63:0] model_hilo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .Op   (Op),
        .A    (A),
        .B    (B),
        .Wr_Hi(Wr_Hi),
        .Wr_Lo(Wr_Lo),
        .Flush(Flush),
        .Busy (Busy),
        .Done (Done),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Architectural result {HI, LO} of one operation, from plain arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MULTU) begin
            p = {32'h0, a} * {32'h0, b};
            return p;
        end
        if (op == OP_MULT) begin
            p = 64'(sa * sb);
            return p;
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIVU) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Launch one operation, watch Busy/Done, compare the result. With
    // disturb set, Start and both MT writes are pulsed mid-operation with
    // fresh operands, which must all be ignored.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [63:0] expected;
        int          busy_cycles;
        bit          done_early;
        expected    = refModel(op, a, b);
        busy_cycles = 0;
        done_early  = 1'b0;
        @(negedge Clk);
        Op    = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Op    = 2'($urandom);
        A     = $urandom;
        B     = $urandom;
        while (Busy && busy_cycles < 40) begin
            busy_cycles++;
            if (Done) done_early = 1'b1;
            if (disturb && busy_cycles == 6) begin
                checkOutput("mt_busy_hi", 64'(HI), 64'(model_hilo[63:32]));
                checkOutput("mt_busy_lo", 64'(LO), 64'(model_hilo[31:0]));
            end
            Start = disturb && busy_cycles == 5;
            Wr_Hi = disturb && busy_cycles == 5;
            Wr_Lo = disturb && busy_cycles == 5;
            if (disturb && busy_cycles == 5) begin
                A = $urandom;
                B = $urandom;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        Wr_Hi = 1'b0;
        Wr_Lo = 1'b0;
        model_hilo = expected;
        checkOutput("busy_cycles", 64'(busy_cycles), 64'd33);
        checkOutput("done_early", 64'(done_early), 64'd0);
        checkOutput("done_pulse", 64'(Done), 64'd1);
        checkOutput("hi", 64'(HI), 64'(expected[63:32]));
        checkOutput("lo", 64'(LO), 64'(expected[31:0]));
        @(negedge Clk);
        checkOutput("done_width", 64'(Done), 64'd0);
    endtask

    initial begin
        bit          seen_done;
        bit          seen_busy;
        int          wait_cycles;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        Reset = 1'b0;
        Start = 1'b0;
        Op    = 2'b00;
        A     = '0;
        B     = '0;
        Wr_Hi = 1'b0;
        Wr_Lo = 1'b0;
        Flush = 1'b0;
        repeat (2) @(negedge Clk);
        checkOutput("reset_busy", 64'(Busy), 64'd0);
        checkOutput("reset_done", 64'(Done), 64'd0);
        checkOutput("reset_hi", 64'(HI), 64'd0);
        checkOutput("reset_lo", 64'(LO), 64'd0);
        Reset = 1'b1;

        // Directed operations
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        applyStimulus(OP_DIVU, 32'd100, 32'd0, 1'b0);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);

        // MTHI, MTLO and both together
        @(negedge Clk);
        A = 32'h1234;
        Wr_Hi = 1'b1;
        @(negedge Clk);
        Wr_Hi = 1'b0;
        model_hilo[63:32] = 32'h1234;
        checkOutput("mthi", 64'(HI), 64'h1234);
        checkOutput("mthi_lo_kept", 64'(LO), 64'(model_hilo[31:0]));
        A = 32'hCAFE_0001;
        Wr_Lo = 1'b1;
        @(negedge Clk);
        Wr_Lo = 1'b0;
        model_hilo[31:0] = 32'hCAFE_0001;
        checkOutput("mtlo", 64'(LO), 64'hCAFE_0001);
        A = 32'h0BAD_F00D;
        Wr_Hi = 1'b1;
        Wr_Lo = 1'b1;
        @(negedge Clk);
        Wr_Hi = 1'b0;
        Wr_Lo = 1'b0;
        model_hilo = {32'h0BAD_F00D, 32'h0BAD_F00D};
        checkOutput("mt_both", {32'(HI), 32'(LO)}, model_hilo);

        // Start and MTHI together: MT lands at once, result overwrites later
        Op    = OP_MULTU;
        A     = 32'd5;
        B     = 32'd6;
        Start = 1'b1;
        Wr_Hi = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Wr_Hi = 1'b0;
        checkOutput("start_mt_hi", 64'(HI), 64'd5);
        wait_cycles = 0;
        while (Busy && wait_cycles < 40) begin
            wait_cycles++;
            @(negedge Clk);
        end
        model_hilo = 64'd30;
        checkOutput("start_mt_result", {32'(HI), 32'(LO)}, model_hilo);

        // Flush in IDLE dominates Start and MT writes
        @(negedge Clk);
        Flush = 1'b1;
        Start = 1'b1;
        Wr_Hi = 1'b1;
        Wr_Lo = 1'b1;
        A     = 32'hDEAD_BEEF;
        @(negedge Clk);
        Flush = 1'b0;
        Start = 1'b0;
        Wr_Hi = 1'b0;
        Wr_Lo = 1'b0;
        checkOutput("flush_idle_busy", 64'(Busy), 64'd0);
        checkOutput("flush_idle_hilo", {32'(HI), 32'(LO)}, model_hilo);

        // Flush at RUN cycle 20
        Op    = OP_MULTU;
        A     = 32'h0001_0001;
        B     = 32'h0000_FFFF;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (19) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        checkOutput("flush_run_busy", 64'(Busy), 64'd0);
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (40) begin
            if (Done) seen_done = 1'b1;
            if (Busy) seen_busy = 1'b1;
            @(negedge Clk);
        end
        checkOutput("flush_run_done", 64'(seen_done), 64'd0);
        checkOutput("flush_run_idle", 64'(seen_busy), 64'd0);
        checkOutput("flush_run_hilo", {32'(HI), 32'(LO)}, model_hilo);

        // Randomized operations, biased toward the interesting divisors
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = $urandom_range(1, 15);
                2: ra = 32'h8000_0000;
                3: begin ra = $urandom_range(0, 1000); rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        // Reset at RUN cycle 10 discards the operation and clears HI/LO
        @(negedge Clk);
        Op    = OP_MULTU;
        A     = 32'h1234_5678;
        B     = 32'h9ABC_DEF0;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkOutput("rst_run_busy", 64'(Busy), 64'd0);
        checkOutput("rst_run_hi", 64'(HI), 64'd0);
        checkOutput("rst_run_lo", 64'(LO), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) seen_done = 1'b1;
            if (Busy) seen_busy = 1'b1;
        end
        checkOutput("rst_run_no_done", 64'(seen_done), 64'd0);
        checkOutput("rst_run_no_busy", 64'(seen_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
